// File: rtl/conv_ola_sequencer_if.sv
`timescale 1ns/1ps
// Block-in / beat-out stream bundle; master is the sequencer side, slave is the producer/consumer side.
interface conv_ola_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_ola_sequencer.sv
`timescale 1ns/1ps
// Overlap-add sequencer around a 4x4 nibble conv unit; out_valid CONV_LAT+1 cycles after the input handshake cycle.
// One block in flight: in_ready only in LOAD, so a stalled output beat holds off the next input block.
module conv_ola_sequencer #(
  parameter int CONV_LAT = 1,
  parameter int BLK_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLK_W-1:0]     num_blocks,
  input  logic [15:0]          taps,
  output logic                 busy,
  output logic                 done,
  conv_ola_sequencer_if.master bus,
  output logic [31:0]          conv_a,
  output logic [31:0]          conv_b,
  input  logic [31:0]          conv_result
);

  localparam int LAT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CONV_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    OUT,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      taps_q;
  logic [15:0]      a_q;
  logic [BLK_W-1:0] blocks_left;
  logic [LAT_W-1:0] lat_cnt;
  logic [3:0]       t0;
  logic [3:0]       t1;
  logic [3:0]       t2;
  logic [15:0]      out_data_q;
  logic             lat_done;
  logic [3:0]       sum0;
  logic [3:0]       sum1;
  logic [3:0]       sum2;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             out_last_c;
  logic             unused_top;

  // The top result nibble carries no convolution lane.
  assign unused_top = ^conv_result[31:28];

  assign lat_done = (lat_cnt == LAT_LAST);
  assign sum0     = conv_result[3:0]  + t0;
  assign sum1     = conv_result[7:4]  + t1;
  assign sum2     = conv_result[11:8] + t2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_blocks == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_done) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = (blocks_left != '0) ? LOAD : FLUSH;
        end
      end
      FLUSH: begin
        out_valid_c = 1'b1;
        out_last_c  = 1'b1;
        if (bus.out_ready) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q      <= '0;
      a_q         <= '0;
      blocks_left <= '0;
      lat_cnt     <= '0;
      t0          <= '0;
      t1          <= '0;
      t2          <= '0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            taps_q      <= taps;
            blocks_left <= num_blocks;
            t0          <= '0;
            t1          <= '0;
            t2          <= '0;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_data;
            lat_cnt <= '0;
          end
        end
        ISSUE: begin
          // Low lanes absorb the previous block's tail; high lanes become the new tail.
          if (lat_done) begin
            out_data_q  <= {conv_result[15:12], sum2, sum1, sum0};
            t0          <= conv_result[19:16];
            t1          <= conv_result[23:20];
            t2          <= conv_result[27:24];
            blocks_left <= blocks_left - BLK_W'(1);
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        OUT: begin
          if (bus.out_ready && (blocks_left == '0)) begin
            out_data_q <= {4'h0, t2, t1, t0};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_q;
  assign conv_a        = {16'h0, a_q};
  assign conv_b        = {16'h0, taps_q};

endmodule

// File: tb/tb_conv_ola_sequencer.sv
`timescale 1ns/1ps
// Drives a CONV_LAT=1 and a CONV_LAT=3 sequencer, each fed by a behavioural conv unit, against a stream-level convolution model.
module tb_conv_ola_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        start_s = '0;
  logic [1:0][7:0]   nb_s = '0;
  logic [1:0][15:0]  taps_s = '0;
  logic [1:0]        busy_s;
  logic [1:0]        done_s;
  logic [1:0][31:0]  ca_s;
  logic [1:0][31:0]  cb_s;
  logic [1:0][31:0]  cr_s;
  logic [1:0]        in_valid_s = '0;
  logic [1:0][15:0]  in_data_s = '0;
  logic [1:0]        out_ready_s = '1;
  logic [1:0]        in_ready_s;
  logic [1:0]        out_valid_s;
  logic [1:0]        out_last_s;
  logic [1:0][15:0]  out_data_s;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode [2] = '{0, 0};
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  logic [15:0] blk_q [$];

  // Combinational 4x4 nibble convolution unit; junk in the unused top nibble.
  function automatic logic [31:0] conv_unit(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    int s;
    r = 32'hF000_0000;
    for (int k = 0; k < 7; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++)
        if (k - i >= 0 && k - i < 4) s += int'(a[4*i +: 4]) * int'(b[4*(k-i) +: 4]);
      r[4*k +: 4] = 4'(s % 16);
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    conv_ola_sequencer_if bus ();
    assign bus.in_valid  = in_valid_s[g];
    assign bus.in_data   = in_data_s[g];
    assign bus.out_ready = out_ready_s[g];
    assign in_ready_s[g]  = bus.in_ready;
    assign out_valid_s[g] = bus.out_valid;
    assign out_last_s[g]  = bus.out_last;
    assign out_data_s[g]  = bus.out_data;
    assign cr_s[g] = conv_unit(ca_s[g][15:0], cb_s[g][15:0]);

    conv_ola_sequencer #(.CONV_LAT(g == 0 ? 1 : 3), .BLK_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start_s[g]),
      .num_blocks  (nb_s[g]),
      .taps        (taps_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .bus         (bus),
      .conv_a      (ca_s[g]),
      .conv_b      (cb_s[g]),
      .conv_result (cr_s[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void exp_push(input int d, input logic [16:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  // Whole-stream linear convolution mod 16, cut into 4-sample beats plus a 3-sample flush.
  function automatic void push_model(input int d, input logic [15:0] h, input int nb);
    int xs [$];
    int ys [$];
    int s;
    logic [15:0] w;
    logic [16:0] e;
    for (int b = 0; b < nb; b++) begin
      w = blk_q[b];
      for (int i = 0; i < 4; i++) xs.push_back(int'(w[4*i +: 4]));
    end
    for (int n = 0; n < 4*nb + 3; n++) begin
      s = 0;
      for (int j = 0; j < 4; j++)
        if (n - j >= 0 && n - j < 4*nb) s += xs[n-j] * int'(h[4*j +: 4]);
      ys.push_back(s % 16);
    end
    if (nb == 0) return;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int i = 0; i < 4; i++) e[4*i +: 4] = 4'(ys[4*b + i]);
      exp_push(d, e);
    end
    e = 17'h10000;
    for (int i = 0; i < 3; i++) e[4*i +: 4] = 4'(ys[4*nb + i]);
    exp_push(d, e);
  endfunction

  task automatic chk_idle_outs(input int d, input string tag);
    chk({tag, "_busy"},      busy_s[d],      0);
    chk({tag, "_done"},      done_s[d],      0);
    chk({tag, "_in_ready"},  in_ready_s[d],  0);
    chk({tag, "_out_valid"}, out_valid_s[d], 0);
    chk({tag, "_out_last"},  out_last_s[d],  0);
    chk({tag, "_out_data"},  out_data_s[d],  0);
    chk({tag, "_conv_a"},    ca_s[d],        0);
    chk({tag, "_conv_b"},    cb_s[d],        0);
  endtask

  task automatic run_job(input int d, input logic [15:0] h, input int nb,
                         input bit stall5, input bit poke, input bit abort);
    int lat;
    int cnt;
    lat = (d == 0) ? 1 : 3;
    push_model(d, h, nb);
    if (stall5 || abort) rdy_mode[d] = 2;
    start_s[d] = 1'b1;
    taps_s[d]  = h;
    nb_s[d]    = 8'(nb);
    tick();
    start_s[d] = 1'b0;
    taps_s[d]  = 16'($urandom);
    nb_s[d]    = 8'($urandom);
    chk("busy_after_start", busy_s[d], 1);
    if (nb == 0) begin
      chk("done_empty_job", done_s[d], 1);
      tick();
      chk("done_one_cycle_empty", done_s[d], 0);
      chk("idle_after_empty", busy_s[d], 0);
      return;
    end
    chk("no_early_done", done_s[d], 0);
    for (int b = 0; b < nb; b++) begin
      if (poke && b == 1) begin
        start_s[d] = 1'b1;
        nb_s[d]    = 8'd0;
        tick();
        start_s[d] = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = blk_q[b];
      cnt = 0;
      while (!in_ready_s[d] && cnt < 200) begin
        tick();
        cnt++;
      end
      if (cnt >= 200) begin
        chk("in_ready_timeout", in_ready_s[d], 1);
        in_valid_s[d] = 1'b0;
        return;
      end
      tick();
      in_valid_s[d] = 1'b0;
      in_data_s[d]  = 16'($urandom);
      for (int c = 0; c < lat; c++) begin
        chk("issue_conv_a", ca_s[d], {16'h0, blk_q[b]});
        chk("issue_conv_b", cb_s[d], {16'h0, h});
        chk("issue_no_out_valid", out_valid_s[d], 0);
        tick();
      end
      chk("latency_out_valid", out_valid_s[d], 1);
      if (abort) begin
        rst = 1'b1;
        #1;
        chk_idle_outs(d, "abort");
        tick();
        rst = 1'b0;
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
        rdy_mode[d] = 0;
        repeat (3) begin
          tick();
          chk("no_done_after_abort", done_s[d], 0);
        end
        return;
      end
      if (stall5 && b == 0) begin
        repeat (5) begin
          chk("stall_in_ready", in_ready_s[d], 0);
          tick();
        end
        rdy_mode[d] = 0;
      end
    end
    cnt = 0;
    while (!done_s[d] && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("done_seen", done_s[d], 1);
    tick();
    chk("done_one_cycle", done_s[d], 0);
    chk("idle_after_done", busy_s[d], 0);
    chk("scoreboard_drained", exp_size(d), 0);
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 2 = held off.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++)
        out_ready_s[d] = (rdy_mode[d] == 0) ? 1'b1 :
                         (rdy_mode[d] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks holds under stall.
  initial begin
    bit [1:0]         prev_stall;
    logic [1:0][16:0] prev_beat;
    logic [16:0]      act;
    logic [16:0]      e;
    prev_stall = '0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act = {out_last_s[d], out_data_s[d]};
        if (rst) begin
          prev_stall[d] = 1'b0;
        end else begin
          if (prev_stall[d]) begin
            chk("stall_hold_valid", out_valid_s[d], 1);
            chk("stall_hold_beat", act, prev_beat[d]);
          end
          if (out_valid_s[d] && !out_ready_s[d])
            chk("stall_no_in_ready", in_ready_s[d], 0);
          if (out_valid_s[d] && out_ready_s[d]) begin
            if (exp_size(d) == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_beat: dut %0d got %h, expected no beat", d, act);
            end else begin
              e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk("out_beat", act, e);
            end
          end
          prev_stall[d] = out_valid_s[d] && !out_ready_s[d];
          prev_beat[d]  = act;
        end
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got no completion by t=%0t, expected finish", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    #1 rst = 1'b1;
    #2;
    chk_idle_outs(0, "reset0");
    chk_idle_outs(1, "reset1");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    blk_q = '{16'h4321};
    run_job(0, 16'h0001, 1, 0, 0, 0);
    blk_q = '{16'h1111, 16'h1111};
    run_job(0, 16'h0011, 2, 0, 1, 0);
    blk_q = '{16'hF000, 16'h0300};
    run_job(0, 16'h1001, 2, 0, 0, 0);

    blk_q = '{16'h1111, 16'h1111};
    run_job(0, 16'h0011, 2, 1, 0, 0);
    run_job(1, 16'h0011, 2, 1, 1, 0);

    blk_q.delete();
    run_job(0, 16'h0011, 0, 0, 0, 0);
    run_job(1, 16'h1234, 0, 0, 0, 0);

    blk_q = '{16'h1111, 16'h1111};
    run_job(0, 16'h0011, 2, 0, 0, 1);
    run_job(0, 16'h0011, 2, 0, 0, 0);

    for (int j = 0; j < 24; j++) begin
      nb = $urandom_range(1, 4);
      blk_q.delete();
      for (int b = 0; b < nb; b++) blk_q.push_back(16'($urandom));
      rdy_mode[j % 2] = 1;
      run_job(j % 2, 16'($urandom), nb, 0, (j % 3) == 0, 0);
      rdy_mode[j % 2] = 0;
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
